dcache_responder: RTL and testbench

//  Responder end of the memory-stage <-> dcache interface: accepts one read or write per request,

---
 rtl/dcache_responder.sv | 117 +++++++++++
 tb/tb_dcache_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// dcache_responder: fixed-latency SRAM responder for the memory-stage dcache port.
// Ports: clk, rst (async high), memory_dcache_{addr,read,write,wdata} in; dcache_memory_{rdata,resp} out.
module dcache_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memory_dcache_addr,
  input  logic        memory_dcache_read,
  input  logic        memory_dcache_write,
  input  logic [31:0] memory_dcache_wdata,
  output logic [31:0] dcache_memory_rdata,
  output logic        dcache_memory_resp
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            wr_q;
  logic [31:0]     mem [DEPTH];

  logic            request;
  logic [IW-1:0]   addr_idx;
  logic [IW-1:0]   tgt_idx;
  logic [31:0]     tgt_wdata;
  logic            tgt_wr;
  logic            enter_resp;
  logic [31:0]     rd_word;
  logic            unused_addr;

  assign request     = memory_dcache_read | memory_dcache_write;
  assign addr_idx    = memory_dcache_addr[2 +: IW];
  assign unused_addr = ^{memory_dcache_addr[31:IW+2], memory_dcache_addr[1:0]};

  // The edge that enters RESP both commits the write and samples read data.
  // In IDLE (only reachable there when LATENCY==1) the live inputs are used
  // since nothing has been latched yet.
  always_comb begin
    tgt_idx    = idx_q;
    tgt_wdata  = wdata_q;
    tgt_wr     = wr_q;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        tgt_idx    = addr_idx;
        tgt_wdata  = memory_dcache_wdata;
        tgt_wr     = memory_dcache_write;
        enter_resp = request && (LATENCY == 1);
      end
      // cnt counts down; its final step (1 -> 0) lands in RESP so the
      // response appears exactly LATENCY cycles after acceptance.
      BUSY: enter_resp = request && (cnt == CW'(1));
      default: enter_resp = 1'b0;
    endcase
  end

  assign rd_word = mem[tgt_idx];

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && tgt_wr) begin
      mem[tgt_idx] <= tgt_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      idx_q               <= '0;
      wdata_q             <= '0;
      wr_q                <= 1'b0;
      dcache_memory_resp  <= 1'b0;
      dcache_memory_rdata <= '0;
    end else begin
      dcache_memory_resp  <= 1'b0;
      dcache_memory_rdata <= '0;
      case (state)
        IDLE: begin
          if (request) begin
            idx_q   <= addr_idx;
            wdata_q <= memory_dcache_wdata;
            wr_q    <= memory_dcache_write;
            cnt     <= CW'(LATENCY - 1);
            state   <= enter_resp ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (!request) begin
            state <= IDLE;
          end else if (enter_resp) begin
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        dcache_memory_resp  <= 1'b1;
        dcache_memory_rdata <= tgt_wr ? 32'h0 : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed checks of dcache_responder (DEPTH=256, LATENCY=2).
// Drives inputs 1 time unit after posedge, samples outputs on negedge.
module tb_dcache_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;

  int tests;
  int fails;

  dcache_responder #(
    .DEPTH(256),
    .LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .memory_dcache_addr(addr),
    .memory_dcache_read(rd),
    .memory_dcache_write(wr),
    .memory_dcache_wdata(wdata),
    .dcache_memory_rdata(rdata),
    .dcache_memory_resp(resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic exp_resp,
                     input logic [31:0] exp_rdata);
    tests++;
    if (resp !== exp_resp) begin
      fails++;
      $display("FAIL %s resp: got %0b want %0b", nm, resp, exp_resp);
    end
    tests++;
    if (rdata !== exp_rdata) begin
      fails++;
      $display("FAIL %s rdata: got %08h want %08h", nm, rdata, exp_rdata);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One transaction from cycle 0; resp expected only in cycle 2.
  task automatic txn(input string nm, input logic [31:0] a, input logic r,
                     input logic w, input logic [31:0] d,
                     input logic [31:0] exp);
    addr  = a;
    rd    = r;
    wr    = w;
    wdata = d;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk($sformatf("%s c%0d", nm, c), 1'b1, exp);
        rd = 1'b0;
        wr = 1'b0;
      end else begin
        chk($sformatf("%s c%0d", nm, c), 1'b0, 32'h0);
      end
      next_cycle();
    end
    @(negedge clk);
    chk($sformatf("%s after", nm), 1'b0, 32'h0);
    next_cycle();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    addr  = 32'h0;
    rd    = 1'b0;
    wr    = 1'b0;
    wdata = 32'h0;
    #1;
    chk("reset async", 1'b0, 32'h0);
    @(negedge clk);
    chk("reset held", 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("idle", 1'b0, 32'h0);
    next_cycle();
  endtask

  task automatic test_write_read();
    txn("write 0x10", 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0);
    txn("read 0x10", 32'h10, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF);
  endtask

  task automatic test_alias();
    txn("read 0x413", 32'h413, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF);
  endtask

  task automatic test_read_write();
    txn("rw 0x20", 32'h20, 1'b1, 1'b1, 32'h12345678, 32'h0);
    txn("read 0x20", 32'h20, 1'b1, 1'b0, 32'h0, 32'h12345678);
  endtask

  task automatic test_withdraw();
    addr  = 32'h20;
    wr    = 1'b1;
    wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("withdraw c0", 1'b0, 32'h0);
    next_cycle();
    wr = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("withdraw c%0d", c), 1'b0, 32'h0);
      next_cycle();
    end
    txn("read after withdraw", 32'h20, 1'b1, 1'b0, 32'h0, 32'h12345678);
  endtask

  task automatic test_mid_reset();
    addr  = 32'h20;
    wr    = 1'b1;
    wdata = 32'h0BADBEEF;
    next_cycle();
    rst = 1'b1;
    #1;
    chk("midrst async", 1'b0, 32'h0);
    @(negedge clk);
    chk("midrst c1", 1'b0, 32'h0);
    @(negedge clk);
    chk("midrst c2", 1'b0, 32'h0);
    rst = 1'b0;
    wr  = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("midrst c3", 1'b0, 32'h0);
    next_cycle();
    txn("read after rst", 32'h20, 1'b1, 1'b0, 32'h0, 32'h12345678);
  endtask

  // Request held high past resp starts a fresh transaction: resp in 2 and 5.
  task automatic test_back_to_back();
    addr = 32'h10;
    rd   = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2 || c == 5) begin
        chk($sformatf("b2b c%0d", c), 1'b1, 32'hDEADBEEF);
      end else begin
        chk($sformatf("b2b c%0d", c), 1'b0, 32'h0);
      end
      if (c == 5) rd = 1'b0;
      next_cycle();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write_read();
    test_alias();
    test_read_write();
    test_withdraw();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded, want completion");
    $fatal(1);
  end

endmodule
